// File: rtl/fetch_ctrl_pkg.sv
// Shared Stage1 fetch definitions: controller state encoding and default widths/constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

  // Fetch controller states; a single memory request is outstanding at most.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // first cycle after reset, no request
    REQ  = 2'd1,  // request asserted, waiting for grant
    WAIT = 2'd2,  // granted, waiting for read data
    HOLD = 2'd3   // instruction presented to decode
  } fetch_state_t;

  // Sequential PC increment in bytes.
  localparam int unsigned PC_STEP_DEFAULT = 4;

  // Default instruction width in bits.
  localparam int unsigned INSTR_W_DEFAULT = 32;

  // Low PC bits that must be zero in any fetch address (word alignment).
  localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/fetch_ctrl.sv
// Stage1 fetch controller: steps the external PC register, issues one imem read per PC, hands instructions to decode.
// Latency: REQ to HOLD is one cycle plus memory latency; one instruction per 3 cycles at best (REQ, WAIT, HOLD).
// Backpressure: decode stalls by holding if_ready low in HOLD; no new request is issued until the instruction is accepted or redirected.
//
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   pc_q / pc_next / pc_en           read-back and write side of the external PC register
//   imem_req/addr/gnt/rvalid/rdata   instruction memory read handshake (single outstanding)
//   redirect_valid/target            taken branch/jump pulse; target low bits are cleared
//   if_valid/instr/pc, if_ready      valid/ready interface towards decode
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int N       = 32,
  parameter int INSTR_W = INSTR_W_DEFAULT,
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       pc_q,
  output logic [N-1:0]       pc_next,
  output logic               pc_en,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [N-1:0]       if_pc,
  input  logic               if_ready
);

  localparam logic [N-1:0] STEP     = N'(PC_STEP);
  localparam logic [N-1:0] LOW_MASK = N'(ALIGN_MASK);

  fetch_state_t state, state_nxt;

  // squash marks the outstanding response as stale (redirected after grant).
  logic         squash, squash_nxt;
  // PC of the request currently in flight, moved to if_pc when its data lands.
  logic [N-1:0] if_pc_r;

  logic         cap_pc;     // latch the granted PC
  logic         cap_instr;  // accept read data into the decode register
  logic         clr_valid;  // decode register consumed or dropped

  logic [N-1:0] target;

  assign target = redirect_target & ~LOW_MASK;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      squash   <= 1'b0;
      if_pc_r  <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state  <= state_nxt;
      squash <= squash_nxt;
      if (cap_pc) begin
        if_pc_r <= pc_q;
      end
      if (cap_instr) begin
        if_instr <= imem_rdata;
        if_pc    <= if_pc_r;
        if_valid <= 1'b1;
      end else if (clr_valid) begin
        if_valid <= 1'b0;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    squash_nxt = squash;
    imem_req   = 1'b0;
    imem_addr  = '0;
    pc_en      = 1'b0;
    pc_next    = '0;
    cap_pc     = 1'b0;
    cap_instr  = 1'b0;
    clr_valid  = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = REQ;
      end

      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (redirect_valid) begin
          // A grant in the same cycle still stands; its response is dropped later.
          pc_en   = 1'b1;
          pc_next = target;
          if (imem_gnt) begin
            squash_nxt = 1'b1;
            state_nxt  = WAIT;
          end
        end else if (imem_gnt) begin
          pc_en     = 1'b1;
          pc_next   = pc_q + STEP;  // wraps modulo 2^N
          cap_pc    = 1'b1;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (squash || redirect_valid) begin
            squash_nxt = 1'b0;
            state_nxt  = REQ;
            if (redirect_valid) begin
              pc_en   = 1'b1;
              pc_next = target;
            end
          end else begin
            cap_instr = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          // Response still owed by memory; remember to drop it.
          pc_en      = 1'b1;
          pc_next    = target;
          squash_nxt = 1'b1;
        end
      end

      HOLD: begin
        // Redirect wins over acceptance: the held instruction is on the wrong path.
        if (redirect_valid) begin
          clr_valid = 1'b1;
          pc_en     = 1'b1;
          pc_next   = target;
          state_nxt = REQ;
        end else if (if_ready) begin
          clr_valid = 1'b1;
          state_nxt = REQ;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a PC register model, a memory model and an in-order scoreboard.
// Latency: n/a.
// Backpressure: decode readiness is driven per test.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.N(32), .INSTR_W(32), .PC_STEP(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_q            (pc_q),
    .pc_next         (pc_next),
    .pc_en           (pc_en),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_ready        (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents: address-dependent, word 0 holds 0x00000013.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  // External PC register.
  logic [31:0] pc_rst_val;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= pc_rst_val;
    else if (pc_en) pc_q <= pc_next;
  end

  // Memory model: grant after gnt_delay cycles of request, data rsp_lat cycles after grant.
  int          gnt_delay;
  int          rsp_lat;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          req_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pend        = 1'b0;
      pend_addr   = '0;
      pend_cnt    = 0;
      req_wait    = 0;
    end else begin
      #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
          // Data may only arrive while the controller waits for it.
          check("proto_rvalid_state", {imem_req, if_valid}, 2'b00);
        end else begin
          pend_cnt--;
        end
      end
      if (imem_req) begin
        if (pend) begin
          check("proto_single_outstanding", pend, 1'b0);
        end else if (req_wait >= gnt_delay) begin
          imem_gnt  = 1'b1;
          pend      = 1'b1;
          pend_addr = imem_addr;
          pend_cnt  = rsp_lat - 1;
          req_wait  = 0;
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
    end
  end

  // Scoreboard: expected deliveries pushed by each test, popped on decode handshakes.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  logic sb_en;

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb_en && if_valid && if_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: delivery if_pc=0x%0h if_instr=0x%0h, none expected", if_pc, if_instr);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", if_instr, e.instr);
      end
    end
  end

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start_pc, input int gd, input int lat);
    pc_rst_val     = start_pc;
    gnt_delay      = gd;
    rsp_lat        = lat;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait at falling edges for a grant cycle (pc_en without redirect).
  task automatic wait_pc_en(input string name);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (pc_en) found = 1'b1;
    end
    check(name, found, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0) done = 1'b1;
    end
    check(name, done, 1'b1);
    tick();
    sb_en = 1'b0;
  endtask

  task automatic wait_req(input string name);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (imem_req) found = 1'b1;
    end
    check(name, found, 1'b1);
  endtask

  typedef struct {
    logic [31:0] start_pc;
    int          gd;
    int          lat;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic hit;
    int   lat_cnt;

    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hit;
    int   lat_cnt;

    vecs[0] = '{32'h0000_0000, 0, 1, 32'h0000_0004};
    vecs[1] = '{32'h0000_0100, 2, 1, 32'h0000_0104};
    vecs[2] = '{32'h1000_0000, 0, 3, 32'h1000_0004};
    vecs[3] = '{32'hFFFF_FFFC, 1, 2, 32'h0000_0000};
    vecs[4] = '{32'h7FFF_FFFC, 0, 1, 32'h8000_0000};

    rst_n           = 1'b1;
    pc_rst_val      = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    if_ready        = 1'b1;
    gnt_delay       = 0;
    rsp_lat         = 1;
    sb_en           = 1'b0;
    #1 rst_n = 1'b0;

    // Reset values.
    #11;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_pc_next", pc_next, 32'h0);

    // Table: single fetch from a start PC with varying memory timing.
    foreach (vecs[i]) begin
      if_ready = 1'b1;
      do_reset(vecs[i].start_pc, vecs[i].gd, vecs[i].lat);
      sb_en = 1'b1;
      push_exp(vecs[i].start_pc);
      wait_pc_en("row_grant_timeout");
      check("row_req", imem_req, 1'b1);
      check("row_addr", imem_addr, vecs[i].start_pc);
      check("row_pc_next", pc_next, vecs[i].exp_next);
      hit = 1'b0;
      lat_cnt = 0;
      for (int c = 0; c < 30 && !hit; c++) begin
        @(negedge clk);
        lat_cnt++;
        if (if_valid) hit = 1'b1;
      end
      check("row_latency", lat_cnt, vecs[i].lat + 1);
      check("row_pc_q", pc_q, vecs[i].exp_next);
      tick();
      check("row_drained", sb_q.size(), 0);
      sb_en = 1'b0;
      wait_req("row_next_req_timeout");
      check("row_next_addr", imem_addr, vecs[i].exp_next);
    end

    // Decode backpressure: instruction held stable, no new request.
    if_ready = 1'b0;
    do_reset(32'h0, 0, 1);
    sb_en = 1'b1;
    push_exp(32'h0);
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (if_valid) hit = 1'b1;
    end
    check("bp_valid_timeout", hit, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("bp_if_valid", if_valid, 1'b1);
      check("bp_if_instr", if_instr, 32'h13);
      check("bp_if_pc", if_pc, 32'h0);
      check("bp_no_req", imem_req, 1'b0);
      check("bp_pc_q", pc_q, 32'h4);
      @(negedge clk);
    end
    tick();
    if_ready = 1'b1;
    @(negedge clk);
    tick();
    check("bp_drained", sb_q.size(), 0);
    sb_en = 1'b0;
    wait_req("bp_next_req_timeout");
    check("bp_next_addr", imem_addr, 32'h4);

    // Redirect while waiting for data: response dropped, fetch resumes at aligned target.
    if_ready = 1'b1;
    do_reset(32'h0, 0, 4);
    sb_en = 1'b1;
    push_exp(32'h100);
    push_exp(32'h104);
    wait_pc_en("rw_grant_timeout");
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    @(negedge clk);
    check("rw_pc_en", pc_en, 1'b1);
    check("rw_pc_next", pc_next, 32'h100);
    check("rw_no_req", imem_req, 1'b0);
    tick();
    redirect_valid = 1'b0;
    wait_req("rw_req_timeout");
    check("rw_addr", imem_addr, 32'h100);
    wait_drain("rw_drain_timeout");

    // Redirect coincident with grant at pc 0x8.
    do_reset(32'h8, 0, 1);
    sb_en = 1'b1;
    push_exp(32'h200);
    push_exp(32'h204);
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      tick();
      if (imem_req) begin
        hit             = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
      end
    end
    @(negedge clk);
    check("rg_addr", imem_addr, 32'h8);
    check("rg_gnt", imem_gnt, 1'b1);
    check("rg_pc_en", pc_en, 1'b1);
    check("rg_pc_next", pc_next, 32'h200);
    tick();
    redirect_valid = 1'b0;
    wait_req("rg_req_timeout");
    check("rg_next_addr", imem_addr, 32'h200);
    wait_drain("rg_drain_timeout");

    // Redirect coincident with if_ready in HOLD: held instruction dropped.
    do_reset(32'h40, 0, 1);
    sb_en = 1'b1;
    push_exp(32'h300);
    push_exp(32'h304);
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      tick();
      if (if_valid) begin
        hit             = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
      end
    end
    @(negedge clk);
    check("rh_if_pc", if_pc, 32'h40);
    check("rh_pc_en", pc_en, 1'b1);
    check("rh_pc_next", pc_next, 32'h300);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rh_if_valid_dropped", if_valid, 1'b0);
    check("rh_addr", imem_addr, 32'h300);
    wait_drain("rh_drain_timeout");

    // Asynchronous reset while waiting for data.
    rsp_lat    = 5;
    pc_rst_val = 32'h0;
    wait_pc_en("ar_grant_timeout");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_imem_req", imem_req, 1'b0);
    check("ar_imem_addr", imem_addr, 32'h0);
    check("ar_pc_en", pc_en, 1'b0);
    check("ar_pc_next", pc_next, 32'h0);
    check("ar_if_valid", if_valid, 1'b0);
    check("ar_if_instr", if_instr, 32'h0);
    check("ar_if_pc", if_pc, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_idle_no_req", imem_req, 1'b0);
    tick();
    @(negedge clk);
    check("ar_req_after_idle", imem_req, 1'b1);
    check("ar_req_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Stage1 fetch controller; drives the write side of the PC register (next value + enable) and reads back its current value.
- Issues one instruction-memory read per PC using a req/gnt/rvalid handshake.
- Presents fetched instructions to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution, including squashing a fetch already in flight.

Parameters:
N, 32, address/PC width in bits
INSTR_W, 32, instruction width in bits
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_q  in  N  current PC value from the PC register
pc_next  out  N  next PC value, wired to the PC register data input
pc_en  out  1  PC register load enable
imem_req  out  1  instruction memory read request
imem_addr  out  N  instruction memory read address
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  read data valid; exactly one per granted request
imem_rdata  in  INSTR_W  read data
redirect_valid  in  1  taken branch/jump; one-cycle pulse
redirect_target  in  N  redirect destination
if_valid  out  1  instruction valid to decode
if_instr  out  INSTR_W  fetched instruction
if_pc  out  N  PC of if_instr
if_ready  in  1  decode accepts the instruction

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, squash=0.
  - Outputs: imem_req=0, pc_en=0, if_valid=0, if_instr=0, if_pc=0, pc_next=0.
- Single outstanding request. Four states: IDLE, REQ, WAIT, HOLD.
- IDLE: go to REQ on the first clock after reset deassertion. No request is issued in IDLE.
- REQ:
  - imem_req=1, imem_addr=pc_q (combinational from pc_q).
  - gnt without redirect: pc_en=1, pc_next=pc_q+PC_STEP (mod 2^N). Latch if_pc_r=pc_q. Go to WAIT.
  - gnt with redirect in the same cycle: grant stands. pc_en=1, pc_next=target. squash<=1. Go to WAIT.
  - redirect without gnt: pc_en=1, pc_next=target. Stay in REQ; req stays high and the address follows pc_q next cycle.
- WAIT:
  - imem_req=0.
  - rvalid with squash=0 and no redirect: capture if_instr<=rdata, if_pc<=if_pc_r. if_valid<=1. Go to HOLD.
  - rvalid with squash=1 or redirect: discard data, squash<=0. If redirect: pc_en=1, pc_next=target. Go to REQ.
  - redirect without rvalid: pc_en=1, pc_next=target. squash<=1. Stay in WAIT.
- HOLD:
  - if_valid=1; if_instr and if_pc are held stable until accepted.
  - redirect (takes priority over if_ready): if_valid<=0, pc_en=1, pc_next=target. Go to REQ.
  - if_ready without redirect: if_valid<=0. Go to REQ.
- pc_en=0 in every case not listed above; pc_next is don't-care when pc_en=0.
- Redirect target: bits [1:0] are forced to 0 before use.
- PC wrap: 0xFFFFFFFC+4 -> 0x00000000. No error is flagged.
- Latency:
  - REQ to HOLD is 1 cycle plus memory latency.
  - Minimum throughput is one instruction per 3 cycles (REQ, WAIT, HOLD). This is accepted.
- rvalid seen in REQ, HOLD or IDLE is a protocol error. It is ignored; the bench asserts it never occurs.
- Reset mid-operation returns to IDLE immediately. Any in-flight memory response after reset is the memory's responsibility; the memory is reset together with this block.

Decomposition:
- Shared Stage1 package holds:
  - the fetch_state_t enum (IDLE, REQ, WAIT, HOLD);
  - PC_STEP;
  - the INSTR_W default;
  - ALIGN_MASK.
- No sub-module. The PC register stays a separate instance in Stage1, connected via pc_q / pc_next / pc_en.

Test Plan:
- Reset, PC register loads 0x00000000, memory gnt same cycle, rvalid 1 cycle later with 0x00000013, if_ready=1 -> pc_en pulse with pc_next=0x4; if_valid with if_instr=0x00000013, if_pc=0x0; next request addr=0x4.
- Decode backpressure: if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc stay constant; no imem_req; pc_q unchanged.
- Redirect to 0x00000103 during WAIT -> pc_next=0x100 with pc_en; the later rvalid is dropped (no if_valid); next imem_addr=0x100.
- Redirect coincident with imem_gnt in REQ at pc=0x8 -> response for 0x8 is squashed; next fetch from the target; exactly one if_valid, for the target instruction.
- Redirect coincident with if_ready in HOLD -> the held instruction is dropped; no duplicate; fetch resumes at the target.
- pc_q=0xFFFFFFFC granted -> pc_next=0x00000000; async reset asserted in WAIT -> all outputs 0 within the same cycle, state IDLE.
